// File: rtl/axil_seq_pkg.sv
// Shared types and helpers for the AXI4-Lite sequential write/read-back master.
package axil_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Error counter increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axil_seq_master_if.sv
// AXI4-Lite bus bundle between the sequential master and the register slave.
interface axil_seq_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_seq_master.sv
// AXI4-Lite master that writes C_NUM_REGS incrementing words to consecutive
// registers, reads them all back, and reports pass/fail plus an error count.
module axil_seq_master
    import axil_seq_pkg::*;
#(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter int                              C_NUM_REGS         = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = '0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]   C_START_DATA       = 1,
    parameter int                              C_TIMEOUT          = 1023
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_cnt,
    axil_seq_master_if.master   m_axi
);
    localparam int                IDX_W    = 4;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(C_NUM_REGS - 1);
    localparam int                TMO_W    = $clog2(C_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(C_TIMEOUT - 1);

    state_e                         state_q;
    logic [IDX_W-1:0]               idx_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]  data_q;
    logic [TMO_W-1:0]               tmo_q;
    logic [7:0]                     err_q;
    logic                           busy_q, done_q, pass_q;
    logic                           awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

    logic aw_ok, w_ok, tmo_hit, rd_bad, last_idx;

    // Address and data are shared by the write and read phases: both walk idx.
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wdata   = data_q;
    assign m_axi.wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

    // Handshake qualifiers: a channel counts as accepted once its VALID has dropped.
    always_comb begin
        aw_ok    = 1'b0;
        w_ok     = 1'b0;
        tmo_hit  = 1'b0;
        rd_bad   = 1'b0;
        last_idx = 1'b0;
        aw_ok    = !awvalid_q || m_axi.awready;
        w_ok     = !wvalid_q  || m_axi.wready;
        tmo_hit  = (tmo_q == TMO_LAST);
        rd_bad   = (m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rdata != data_q);
        last_idx = (idx_q == IDX_LAST);
    end

    // Sequencer FSM with registered bus controls and status outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= C_BASE_ADDR;
            data_q    <= C_START_DATA;
            tmo_q     <= '0;
            err_q     <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q     <= 8'h00;
                        idx_q     <= '0;
                        addr_q    <= C_BASE_ADDR;
                        data_q    <= C_START_DATA;
                        busy_q    <= 1'b1;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (aw_ok && w_ok) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= WR_RESP;
                    end else if (tmo_hit) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        err_q     <= sat_inc(err_q);
                        state_q   <= DONE;
                    end else begin
                        if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                        if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_q <= 1'b0;
                        tmo_q    <= '0;
                        if (m_axi.bresp != AXI_RESP_OKAY) err_q <= sat_inc(err_q);
                        if (!last_idx) begin
                            idx_q     <= idx_q + IDX_W'(1);
                            addr_q    <= addr_q + C_M_AXI_ADDR_WIDTH'(4);
                            data_q    <= data_q + C_M_AXI_DATA_WIDTH'(1);
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            idx_q     <= '0;
                            addr_q    <= C_BASE_ADDR;
                            data_q    <= C_START_DATA;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end else if (tmo_hit) begin
                        bready_q <= 1'b0;
                        err_q    <= sat_inc(err_q);
                        state_q  <= DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                RD_REQ: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= RD_DATA;
                    end else if (tmo_hit) begin
                        arvalid_q <= 1'b0;
                        err_q     <= sat_inc(err_q);
                        state_q   <= DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        rready_q <= 1'b0;
                        tmo_q    <= '0;
                        if (rd_bad) err_q <= sat_inc(err_q);
                        if (!last_idx) begin
                            idx_q     <= idx_q + IDX_W'(1);
                            addr_q    <= addr_q + C_M_AXI_ADDR_WIDTH'(4);
                            data_q    <= data_q + C_M_AXI_DATA_WIDTH'(1);
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (tmo_hit) begin
                        rready_q <= 1'b0;
                        err_q    <= sat_inc(err_q);
                        state_q  <= DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == 8'h00);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
